// File: rtl/lcd_timing_pkg.sv
// Shared types and timing arithmetic for the LCD pixel reader.
// Holds the scan-out state encoding and the frame-total helpers.
package lcd_timing_pkg;

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } state_t;

    function automatic int h_total(int active, int front, int sync, int back);
        return active + front + sync + back;
    endfunction

    function automatic int v_total(int active, int front, int sync, int back);
        return active + front + sync + back;
    endfunction

    // Counter width large enough to also represent the total itself,
    // so window end points equal to the total do not wrap.
    function automatic int count_width(int total);
        return $clog2(total + 1);
    endfunction

endpackage

// File: rtl/lcd_timing_counter.sv
// Horizontal/vertical raster counters with sync, active and frame decode.
// Counters sit at zero whenever run is low.
module lcd_timing_counter
    import lcd_timing_pkg::*;
#(
    parameter int H_ACTIVE = 480,
    parameter int H_FRONT  = 8,
    parameter int H_SYNC   = 4,
    parameter int H_BACK   = 43,
    parameter int V_ACTIVE = 272,
    parameter int V_FRONT  = 4,
    parameter int V_SYNC   = 4,
    parameter int V_BACK   = 12
) (
    input  logic clock,
    input  logic reset,
    input  logic run,
    output logic active,
    output logic hsync,
    output logic vsync,
    output logic frame_first,
    output logic frame_end
);

    localparam int H_TOTAL = h_total(H_ACTIVE, H_FRONT, H_SYNC, H_BACK);
    localparam int V_TOTAL = v_total(V_ACTIVE, V_FRONT, V_SYNC, V_BACK);
    localparam int HW      = count_width(H_TOTAL);
    localparam int VW      = count_width(V_TOTAL);

    localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT_END  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_SYNC_BEG = HW'(H_ACTIVE + H_FRONT);
    localparam logic [HW-1:0] H_SYNC_END = HW'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT_END  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_SYNC_BEG = VW'(V_ACTIVE + V_FRONT);
    localparam logic [VW-1:0] V_SYNC_END = VW'(V_ACTIVE + V_FRONT + V_SYNC);

    logic [HW-1:0] h;
    logic [VW-1:0] v;
    logic          h_wrap;

    assign h_wrap = (h == H_LAST);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            h <= '0;
            v <= '0;
        end else if (!run) begin
            h <= '0;
            v <= '0;
        end else if (h_wrap) begin
            h <= '0;
            v <= (v == V_LAST) ? '0 : v + 1'b1;
        end else begin
            h <= h + 1'b1;
        end
    end

    // NOTE: every output of a combinational block is assigned on every path,
    // otherwise synthesis infers a latch to hold the old value.
    always_comb begin
        active      = (h < H_ACT_END) && (v < V_ACT_END);
        hsync       = !((h >= H_SYNC_BEG) && (h < H_SYNC_END));
        vsync       = !((v >= V_SYNC_BEG) && (v < V_SYNC_END));
        frame_first = (h == '0) && (v == '0);
        frame_end   = h_wrap && (v == V_LAST);
    end

endmodule

// File: rtl/lcd_pixel_reader.sv
// Streams pixels from a show-ahead FIFO onto an RGB LCD panel.
// Waits for a prefill level, then scans whole frames with registered outputs.
module lcd_pixel_reader
    import lcd_timing_pkg::*;
#(
    parameter int DATA_WIDTH    = 16,
    parameter int POINTER_WIDTH = 10,
    parameter int H_ACTIVE      = 480,
    parameter int H_FRONT       = 8,
    parameter int H_SYNC        = 4,
    parameter int H_BACK        = 43,
    parameter int V_ACTIVE      = 272,
    parameter int V_FRONT       = 4,
    parameter int V_SYNC        = 4,
    parameter int V_BACK        = 12,
    parameter int PREFILL_LEVEL = 256
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     enable,
    input  logic [POINTER_WIDTH-1:0] fifo_used,
    input  logic [DATA_WIDTH-1:0]    fifo_data,
    output logic                     fifo_acknowledge,
    output logic                     lcd_hsync,
    output logic                     lcd_vsync,
    output logic                     lcd_de,
    output logic [DATA_WIDTH-1:0]    lcd_rgb,
    output logic                     frame_start,
    output logic [15:0]              underflow_count
);

    localparam logic [POINTER_WIDTH-1:0] PREFILL = POINTER_WIDTH'(PREFILL_LEVEL);

    state_t state, state_next;
    logic   running;
    logic   active, hsync, vsync, frame_first, frame_end;
    logic   fifo_empty, starved;

    assign running    = (state == RUN);
    assign fifo_empty = (fifo_used == '0);
    assign starved    = running && active && fifo_empty;

    lcd_timing_counter #(
        .H_ACTIVE (H_ACTIVE),
        .H_FRONT  (H_FRONT),
        .H_SYNC   (H_SYNC),
        .H_BACK   (H_BACK),
        .V_ACTIVE (V_ACTIVE),
        .V_FRONT  (V_FRONT),
        .V_SYNC   (V_SYNC),
        .V_BACK   (V_BACK)
    ) u_timing (
        .clock       (clock),
        .reset       (reset),
        .run         (running),
        .active      (active),
        .hsync       (hsync),
        .vsync       (vsync),
        .frame_first (frame_first),
        .frame_end   (frame_end)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= FILL;
        end else begin
            state <= state_next;
        end
    end

    // A running frame is only left at its last pixel, so dropping enable never truncates it.
    always_comb begin
        state_next       = state;
        fifo_acknowledge = 1'b0;
        case (state)
            FILL: if (enable && (fifo_used >= PREFILL)) state_next = RUN;
            RUN:  if (frame_end && !enable)             state_next = FILL;
        endcase
        if (!reset && running && active && !fifo_empty) fifo_acknowledge = 1'b1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lcd_hsync       <= 1'b1;
            lcd_vsync       <= 1'b1;
            lcd_de          <= 1'b0;
            lcd_rgb         <= '0;
            frame_start     <= 1'b0;
            underflow_count <= '0;
        end else if (running) begin
            lcd_hsync   <= hsync;
            lcd_vsync   <= vsync;
            lcd_de      <= active;
            lcd_rgb     <= fifo_acknowledge ? fifo_data : '0;
            frame_start <= frame_first;
            if (starved && (underflow_count != 16'hFFFF)) begin
                underflow_count <= underflow_count + 16'd1;
            end
        end else begin
            lcd_hsync   <= 1'b1;
            lcd_vsync   <= 1'b1;
            lcd_de      <= 1'b0;
            lcd_rgb     <= '0;
            frame_start <= 1'b0;
        end
    end

endmodule
